// File: rtl/mem_responder.sv
// Word-bus memory responder: word-addressed RAM plus an MMIO window holding a
// console TX FIFO, a free-running cycle counter, a drop counter and a halt/exit register.
module mem_responder #(
    parameter int          MEM_WORDS  = 4096,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] exit_code
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [13:0] OFF_TX     = 14'h0000;
    localparam logic [13:0] OFF_STATUS = 14'h0001;
    localparam logic [13:0] OFF_CYCLE  = 14'h0002;
    localparam logic [13:0] OFF_HALT   = 14'h0003;
    localparam logic [13:0] OFF_DROPS  = 14'h0004;

    logic [31:0] r_mem [MEM_WORDS];
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic [31:0]   r_cycle;
    logic [15:0]   r_drops;
    logic          r_halt;
    logic [31:0]   r_exit;

    logic          w_mmio;
    logic [13:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_halt_wr;
    logic [31:0]   w_count32;
    logic [3:0]    w_cnt_disp;
    logic [1:0]    w_unused;

    assign w_mmio     = (address[31:16] == MMIO_BASE[31:16]);
    assign w_off      = address[15:2];
    assign w_idx      = address[AW+1:2];
    assign w_unused   = address[1:0];
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_push_req = we & w_mmio & (w_off == OFF_TX) & ~r_halt;
    assign w_pop      = ~w_empty & tx_ready;
    // When full, a push is only accepted if the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_halt_wr  = we & w_mmio & (w_off == OFF_HALT) & ~r_halt;
    assign w_count32  = 32'(r_count);
    assign w_cnt_disp = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];

    assign tx_valid  = ~w_empty;
    assign tx_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign halt      = r_halt;
    assign exit_code = r_exit;

    always_ff @(posedge clk) begin
        if (resetn && we && !r_halt && !w_mmio) r_mem[w_idx] <= wdata;
        if (resetn && w_push) r_fifo[r_wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_cycle  <= '0;
            r_drops  <= '0;
            r_halt   <= 1'b0;
            r_exit   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && r_drops != 16'hFFFF) r_drops <= r_drops + 1'b1;
            if (!r_halt) r_cycle <= r_cycle + 1'b1;
            if (w_halt_wr) begin
                r_halt <= 1'b1;
                r_exit <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (w_mmio) begin
            case (w_off)
                OFF_STATUS: rdata = {20'b0, w_cnt_disp, 6'b0, w_empty, w_full};
                OFF_CYCLE:  rdata = r_cycle;
                OFF_HALT:   rdata = r_exit;
                OFF_DROPS:  rdata = {16'b0, r_drops};
                default:    rdata = '0;
            endcase
        end else begin
            rdata = r_mem[w_idx];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM aliasing, TX FIFO order/overflow,
// cycle counter, halt behaviour and synchronous reset.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [31:0] exit_code;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] A_TX     = 32'hFFFF_0000;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
    localparam logic [31:0] A_HALT   = 32'hFFFF_000C;
    localparam logic [31:0] A_DROPS  = 32'hFFFF_0010;
    localparam logic [31:0] A_UNMAP  = 32'hFFFF_0020;

    mem_responder dut (
        .clk       (clk),
        .resetn    (resetn),
        .address   (address),
        .wdata     (wdata),
        .we        (we),
        .rdata     (rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address = a;
        wdata   = d;
        we      = 1'b1;
        step();
        we      = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = rdata;
    endtask

    logic [31:0] v;
    logic [31:0] c1;
    logic [31:0] c2;

    initial begin
        resetn = 1'b0; address = '0; wdata = '0; we = 1'b0; tx_ready = 1'b0;
        step(); step();
        resetn = 1'b1;

        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_exit", exit_code, 32'd0);
        rd(A_CYCLE, v);  chk("rst_cycle", v, 32'd0);
        rd(A_STATUS, v); chk("rst_status", v, 32'h0000_0002);
        rd(A_DROPS, v);  chk("rst_drops", v, 32'd0);

        // RAM and aliasing
        wr(32'h0000_0100, 32'hDEAD_BEEF);
        rd(32'h0000_0100, v); chk("ram_rd", v, 32'hDEAD_BEEF);
        rd(32'h0000_4100, v); chk("ram_alias", v, 32'hDEAD_BEEF);
        rd(32'h0000_0103, v); chk("ram_byteoff", v, 32'hDEAD_BEEF);

        // Cycle counter and unmapped offsets
        rd(A_CYCLE, c1);
        repeat (7) step();
        rd(A_CYCLE, c2); chk("cycle_diff", c2 - c1, 32'd7);
        wr(A_UNMAP, 32'h1234_5678);
        rd(A_UNMAP, v); chk("unmapped", v, 32'd0);
        rd(A_TX, v);    chk("tx_reads0", v, 32'd0);

        // TX order
        wr(A_TX, 32'h41); wr(A_TX, 32'h42); wr(A_TX, 32'h43);
        rd(A_STATUS, v); chk("status_cnt3", v, 32'h0000_0300);
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'h41);
        step();
        chk("hold_stable", 32'(tx_data), 32'h41);
        tx_ready = 1'b1; #1;
        chk("tx_A", 32'(tx_data), 32'h41);
        step(); chk("tx_B", 32'(tx_data), 32'h42);
        step(); chk("tx_C", 32'(tx_data), 32'h43);
        step(); chk("tx_drained", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // No bypass into an empty FIFO
        address = A_TX; wdata = 32'h44; we = 1'b1; #1;
        chk("nobypass", 32'(tx_valid), 32'd0);
        step(); we = 1'b0;
        chk("push_visible", 32'(tx_valid), 32'd1);
        chk("push_data", 32'(tx_data), 32'h44);
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
        chk("empty_again", 32'(tx_valid), 32'd0);

        // Overflow
        for (int i = 0; i < 10; i++) wr(A_TX, 32'h30 + 32'(i));
        rd(A_STATUS, v); chk("ovf_status", v, 32'h0000_0801);
        rd(A_DROPS, v);  chk("ovf_drops", v, 32'd2);
        chk("ovf_head", 32'(tx_data), 32'h30);
        tx_ready = 1'b1;
        wr(A_TX, 32'h99);
        tx_ready = 1'b0;
        rd(A_STATUS, v); chk("pushpop_status", v, 32'h0000_0801);
        rd(A_DROPS, v);  chk("pushpop_drops", v, 32'd2);
        chk("pushpop_head", 32'(tx_data), 32'h31);
        tx_ready = 1'b1;
        repeat (7) step();
        chk("ovf_tail", 32'(tx_data), 32'h99);
        step();
        chk("ovf_drained", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // Reset mid-operation
        wr(32'h0000_0200, 32'h1234_5678);
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h50 + 32'(i));
        chk("pre_rst_valid", 32'(tx_valid), 32'd1);
        resetn = 1'b0; address = 32'h0000_0200; wdata = 32'h0000_0BAD; we = 1'b1;
        step();
        resetn = 1'b1; we = 1'b0;
        chk("mrst_valid", 32'(tx_valid), 32'd0);
        chk("mrst_data", 32'(tx_data), 32'd0);
        rd(A_CYCLE, v); chk("mrst_cycle", v, 32'd0);
        rd(A_DROPS, v); chk("mrst_drops", v, 32'd0);
        rd(32'h0000_0200, v); chk("mrst_ram_kept", v, 32'h1234_5678);

        // Halt
        wr(A_TX, 32'h61);
        wr(A_HALT, 32'h2A);
        chk("halt_set", 32'(halt), 32'd1);
        chk("halt_exit", exit_code, 32'h2A);
        rd(A_HALT, v); chk("halt_rd", v, 32'h2A);
        wr(32'h0000_0100, 32'h1111_1111);
        rd(32'h0000_0100, v); chk("halt_ram_ign", v, 32'hDEAD_BEEF);
        rd(A_CYCLE, c1);
        repeat (5) step();
        rd(A_CYCLE, c2); chk("halt_cycle_frozen", c2 - c1, 32'd0);
        wr(A_HALT, 32'h7);
        chk("halt_exit_sticky", exit_code, 32'h2A);
        wr(A_TX, 32'h62);
        rd(A_STATUS, v); chk("halt_push_ign", v, 32'h0000_0100);
        chk("halt_head", 32'(tx_data), 32'h61);
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
        chk("halt_drain", 32'(tx_valid), 32'd0);

        // Reset clears halt
        resetn = 1'b0; step(); resetn = 1'b1;
        chk("rst2_halt", 32'(halt), 32'd0);
        chk("rst2_exit", exit_code, 32'd0);
        step();
        rd(A_CYCLE, v); chk("rst2_cycle_runs", v, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
